// File: rtl/multiport_tcm_pkg.sv
// Shared types and helpers for the multi-port tightly coupled memory.
// Holds the request address/size widths, the access-size encoding and
// the size-to-bytecount conversion used by every port.
package multiport_tcm_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int SIZE_WIDTH = 2;
    // Wide enough to hold a byte count of up to 16 (largest bus width).
    localparam int NB_WIDTH   = 5;

    typedef enum logic [SIZE_WIDTH-1:0] {
        SIZE_1B = 2'd0,
        SIZE_2B = 2'd1,
        SIZE_4B = 2'd2,
        SIZE_8B = 2'd3
    } size_e;

    // Number of bytes touched by an access of the given size code.
    function automatic logic [NB_WIDTH-1:0] size_to_bytes(input logic [SIZE_WIDTH-1:0] size);
        logic [NB_WIDTH-1:0] nbytes;
        case (size_e'(size))
            SIZE_1B: nbytes = NB_WIDTH'(1);
            SIZE_2B: nbytes = NB_WIDTH'(2);
            SIZE_4B: nbytes = NB_WIDTH'(4);
            default: nbytes = NB_WIDTH'(8);
        endcase
        return nbytes;
    endfunction

endpackage

// File: rtl/multiport_tcm_if.sv
// Request/response bundle of the TCM: one fetch read port, one load read
// port and one store write port. The master side issues requests, the
// slave side (the memory) returns responses and the store error flag.
interface multiport_tcm_if
    import multiport_tcm_pkg::*;
#(
    parameter int BUS_BYTES = 8
) ();

    // Fetch read port
    logic                      fetch_req_valid;
    logic [ADDR_WIDTH-1:0]     fetch_req_addr;
    logic                      fetch_rsp_valid;
    logic [BUS_BYTES*8-1:0]    fetch_rsp_data;
    logic                      fetch_rsp_err;

    // Load read port
    logic                      ld_req_valid;
    logic [ADDR_WIDTH-1:0]     ld_req_addr;
    logic [SIZE_WIDTH-1:0]     ld_req_size;
    logic                      ld_rsp_valid;
    logic [BUS_BYTES*8-1:0]    ld_rsp_data;
    logic                      ld_rsp_err;

    // Store write port
    logic                      st_req_valid;
    logic [ADDR_WIDTH-1:0]     st_req_addr;
    logic [SIZE_WIDTH-1:0]     st_req_size;
    logic [BUS_BYTES*8-1:0]    st_req_data;
    logic                      st_err;

    modport master (
        output fetch_req_valid, fetch_req_addr,
        input  fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        output ld_req_valid, ld_req_addr, ld_req_size,
        input  ld_rsp_valid, ld_rsp_data, ld_rsp_err,
        output st_req_valid, st_req_addr, st_req_size, st_req_data,
        input  st_err
    );

    modport slave (
        input  fetch_req_valid, fetch_req_addr,
        output fetch_rsp_valid, fetch_rsp_data, fetch_rsp_err,
        input  ld_req_valid, ld_req_addr, ld_req_size,
        output ld_rsp_valid, ld_rsp_data, ld_rsp_err,
        input  st_req_valid, st_req_addr, st_req_size, st_req_data,
        output st_err
    );

endinterface

// File: rtl/multiport_tcm_bank.sv
// One byte-wide bank of the TCM: a single write port and two registered
// read ports. A read of the row being written in the same cycle returns
// the new byte, so a same-cycle store is visible to both readers.
// Contents have no reset and survive the system reset.
module tcm_bank
    import multiport_tcm_pkg::*;
#(
    parameter int DEPTH = 8192,
    parameter int ROW_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ROW_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic             a_re,
    input  logic [ROW_W-1:0] a_addr,
    output logic [7:0]       a_data,
    input  logic             b_re,
    input  logic [ROW_W-1:0] b_addr,
    output logic [7:0]       b_data
);

    logic [7:0] mem [DEPTH];

    // Byte write into the storage array.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port A with write-first bypass.
    always_ff @(posedge clk) begin
        if (a_re) begin
            a_data <= (we && (waddr == a_addr)) ? wdata : mem[a_addr];
        end
    end

    // Read port B with write-first bypass.
    always_ff @(posedge clk) begin
        if (b_re) begin
            b_data <= (we && (waddr == b_addr)) ? wdata : mem[b_addr];
        end
    end

endmodule

// File: rtl/multiport_tcm.sv
// Multi-port tightly coupled memory: one fetch, one load and one store
// per cycle with no back-pressure. Storage is split into BUS_BYTES
// byte-wide banks so an unaligned access touches every bank at most once:
// banks at or above the start lane use row R, banks below it use row R+1.
// The address decode (lane/row/range check) and the byte rotation are
// common to all three ports. Read responses come 1+OUT_REG cycles after
// the request; an out-of-range read returns zero data with err set and an
// out-of-range store writes nothing and raises st_err for one cycle.
module multiport_tcm
    import multiport_tcm_pkg::*;
#(
    parameter int                    BUS_BYTES = 8,
    parameter int                    TCM_SIZE  = 65536,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                    OUT_REG   = 0
) (
    input  logic           clk,
    input  logic           rst,
    multiport_tcm_if.slave bus
);

    localparam int LANE_W  = $clog2(BUS_BYTES);
    localparam int ROWS    = TCM_SIZE / BUS_BYTES;
    localparam int OFF_W   = $clog2(TCM_SIZE);
    localparam int ROW_W   = OFF_W - LANE_W;
    localparam int DATA_W  = BUS_BYTES * 8;
    localparam int AW1     = ADDR_WIDTH + 1;
    localparam int NPORT   = 3;
    localparam int P_FETCH = 0;
    localparam int P_LD    = 1;
    localparam int P_ST    = 2;

    // Bank b holds access byte (b - lane): rotate access data onto the banks.
    function automatic logic [DATA_W-1:0] rotate_to_banks(input logic [DATA_W-1:0] data,
                                                          input logic [LANE_W-1:0] lane);
        logic [DATA_W-1:0] r;
        logic [LANE_W-1:0] src;
        r = '0;
        for (int b = 0; b < BUS_BYTES; b++) begin
            src = LANE_W'(b) - lane;
            r[b*8 +: 8] = data[src*8 +: 8];
        end
        return r;
    endfunction

    // Access byte k lives in bank (lane + k): gather bank bytes into order.
    function automatic logic [DATA_W-1:0] rotate_from_banks(input logic [DATA_W-1:0] bank_bytes,
                                                            input logic [LANE_W-1:0] lane);
        logic [DATA_W-1:0] r;
        logic [LANE_W-1:0] src;
        r = '0;
        for (int k = 0; k < BUS_BYTES; k++) begin
            src = LANE_W'(k) + lane;
            r[k*8 +: 8] = bank_bytes[src*8 +: 8];
        end
        return r;
    endfunction

    // Zero every byte at or above nbytes.
    function automatic logic [DATA_W-1:0] keep_low_bytes(input logic [DATA_W-1:0] data,
                                                         input logic [NB_WIDTH-1:0] nbytes);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < BUS_BYTES; k++) begin
            if (NB_WIDTH'(k) < nbytes) begin
                r[k*8 +: 8] = data[k*8 +: 8];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Per-port request view, indexed fetch / load / store.
    // ------------------------------------------------------------------
    logic                  port_valid    [NPORT];
    logic [ADDR_WIDTH-1:0] port_addr     [NPORT];
    logic [NB_WIDTH-1:0]   port_nbytes   [NPORT];
    logic                  port_size_err [NPORT];

    assign port_valid[P_FETCH]    = bus.fetch_req_valid;
    assign port_addr[P_FETCH]     = bus.fetch_req_addr;
    assign port_nbytes[P_FETCH]   = NB_WIDTH'(BUS_BYTES);
    assign port_size_err[P_FETCH] = 1'b0;

    assign port_valid[P_LD]       = bus.ld_req_valid;
    assign port_addr[P_LD]        = bus.ld_req_addr;
    assign port_nbytes[P_LD]      = size_to_bytes(bus.ld_req_size);
    assign port_size_err[P_LD]    = size_to_bytes(bus.ld_req_size) > NB_WIDTH'(BUS_BYTES);

    assign port_valid[P_ST]       = bus.st_req_valid;
    assign port_addr[P_ST]        = bus.st_req_addr;
    assign port_nbytes[P_ST]      = size_to_bytes(bus.st_req_size);
    assign port_size_err[P_ST]    = size_to_bytes(bus.st_req_size) > NB_WIDTH'(BUS_BYTES);

    // ------------------------------------------------------------------
    // Shared decode: range check, start lane, per-bank row and byte select.
    // ------------------------------------------------------------------
    logic                  port_err  [NPORT];
    logic [LANE_W-1:0]     port_lane [NPORT];
    logic [ROW_W-1:0]      bank_row  [NPORT][BUS_BYTES];
    logic                  bank_sel  [NPORT][BUS_BYTES];

    genvar gi, gb;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_port
            logic [ADDR_WIDTH-1:0] offset;
            logic [ROW_W-1:0]      row;
            logic [ROW_W-1:0]      row_next;

            // Addresses below the base wrap to huge offsets and fail the range check.
            assign offset        = port_addr[gi] - BASE_ADDR;
            assign port_err[gi]  = port_size_err[gi] ||
                                   ({1'b0, offset} > (AW1'(TCM_SIZE) - AW1'(port_nbytes[gi])));
            assign port_lane[gi] = offset[LANE_W-1:0];
            assign row           = offset[OFF_W-1:LANE_W];
            assign row_next      = row + ROW_W'(1);

            for (gb = 0; gb < BUS_BYTES; gb++) begin : g_bank
                logic [LANE_W-1:0] idx;
                assign idx                = LANE_W'(gb) - port_lane[gi];
                assign bank_row[gi][gb]   = (LANE_W'(gb) >= port_lane[gi]) ? row : row_next;
                assign bank_sel[gi][gb]   = NB_WIDTH'(idx) < port_nbytes[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Banks
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] st_bank_data;
    logic              st_commit;
    logic [DATA_W-1:0] fetch_bank_q;
    logic [DATA_W-1:0] ld_bank_q;

    assign st_bank_data = rotate_to_banks(bus.st_req_data, port_lane[P_ST]);
    assign st_commit    = port_valid[P_ST] && !port_err[P_ST] && !rst;

    generate
        for (gb = 0; gb < BUS_BYTES; gb++) begin : g_banks
            tcm_bank #(
                .DEPTH (ROWS),
                .ROW_W (ROW_W)
            ) u_bank (
                .clk    (clk),
                .we     (st_commit && bank_sel[P_ST][gb]),
                .waddr  (bank_row[P_ST][gb]),
                .wdata  (st_bank_data[gb*8 +: 8]),
                .a_re   (port_valid[P_FETCH] && bank_sel[P_FETCH][gb]),
                .a_addr (bank_row[P_FETCH][gb]),
                .a_data (fetch_bank_q[gb*8 +: 8]),
                .b_re   (port_valid[P_LD] && bank_sel[P_LD][gb]),
                .b_addr (bank_row[P_LD][gb]),
                .b_data (ld_bank_q[gb*8 +: 8])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // First response stage: track what the banks are returning.
    // ------------------------------------------------------------------
    logic                f_valid_reg;
    logic                f_err_reg;
    logic [LANE_W-1:0]   f_lane_reg;
    logic                l_valid_reg;
    logic                l_err_reg;
    logic [LANE_W-1:0]   l_lane_reg;
    logic [NB_WIDTH-1:0] l_nbytes_reg;
    logic                st_err_reg;

    // Capture request attributes alongside the bank read; reset drops in-flight reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_valid_reg  <= 1'b0;
            f_err_reg    <= 1'b0;
            f_lane_reg   <= '0;
            l_valid_reg  <= 1'b0;
            l_err_reg    <= 1'b0;
            l_lane_reg   <= '0;
            l_nbytes_reg <= '0;
            st_err_reg   <= 1'b0;
        end else begin
            f_valid_reg  <= port_valid[P_FETCH];
            f_err_reg    <= port_valid[P_FETCH] && port_err[P_FETCH];
            f_lane_reg   <= port_lane[P_FETCH];
            l_valid_reg  <= port_valid[P_LD];
            l_err_reg    <= port_valid[P_LD] && port_err[P_LD];
            l_lane_reg   <= port_lane[P_LD];
            l_nbytes_reg <= port_nbytes[P_LD];
            st_err_reg   <= port_valid[P_ST] && port_err[P_ST];
        end
    end

    assign bus.st_err = st_err_reg;

    logic [DATA_W-1:0] f_data_next;
    logic [DATA_W-1:0] l_data_next;

    // Reassemble bank bytes into response order; zero when idle or in error.
    always_comb begin
        f_data_next = '0;
        l_data_next = '0;
        if (f_valid_reg && !f_err_reg) begin
            f_data_next = rotate_from_banks(fetch_bank_q, f_lane_reg);
        end
        if (l_valid_reg && !l_err_reg) begin
            l_data_next = keep_low_bytes(rotate_from_banks(ld_bank_q, l_lane_reg), l_nbytes_reg);
        end
    end

    // ------------------------------------------------------------------
    // Optional output register stage.
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              f_rsp_valid_reg;
            logic              f_rsp_err_reg;
            logic [DATA_W-1:0] f_rsp_data_reg;
            logic              l_rsp_valid_reg;
            logic              l_rsp_err_reg;
            logic [DATA_W-1:0] l_rsp_data_reg;

            // Hold the already-read response so a following store cannot alter it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    f_rsp_valid_reg <= 1'b0;
                    f_rsp_err_reg   <= 1'b0;
                    f_rsp_data_reg  <= '0;
                    l_rsp_valid_reg <= 1'b0;
                    l_rsp_err_reg   <= 1'b0;
                    l_rsp_data_reg  <= '0;
                end else begin
                    f_rsp_valid_reg <= f_valid_reg;
                    f_rsp_err_reg   <= f_err_reg;
                    f_rsp_data_reg  <= f_data_next;
                    l_rsp_valid_reg <= l_valid_reg;
                    l_rsp_err_reg   <= l_err_reg;
                    l_rsp_data_reg  <= l_data_next;
                end
            end

            assign bus.fetch_rsp_valid = f_rsp_valid_reg;
            assign bus.fetch_rsp_err   = f_rsp_err_reg;
            assign bus.fetch_rsp_data  = f_rsp_data_reg;
            assign bus.ld_rsp_valid    = l_rsp_valid_reg;
            assign bus.ld_rsp_err      = l_rsp_err_reg;
            assign bus.ld_rsp_data     = l_rsp_data_reg;
        end else begin : g_out_comb
            assign bus.fetch_rsp_valid = f_valid_reg;
            assign bus.fetch_rsp_err   = f_err_reg;
            assign bus.fetch_rsp_data  = f_data_next;
            assign bus.ld_rsp_valid    = l_valid_reg;
            assign bus.ld_rsp_err      = l_err_reg;
            assign bus.ld_rsp_data     = l_data_next;
        end
    endgenerate

endmodule

// File: doc/multiport_tcm.md
MULTIPORT_TCM -- requirements
Module: multiport_tcm

Interface
REQ-001 The module SHALL have parameter BUS_BYTES, default 8, meaning the read bus width in bytes and the bank count (power of two, 4..16).
REQ-002 The module SHALL have parameter TCM_SIZE, default 65536, meaning the capacity in bytes (power of two, multiple of BUS_BYTES).
REQ-003 The module SHALL have parameter BASE_ADDR, default 0x8000_0000, meaning the byte address of TCM offset 0 (TCM_SIZE-aligned).
REQ-004 The module SHALL have parameter OUT_REG, default 0, meaning read latency 1 when 0 and 2 when 1.
REQ-005 The module SHALL have ports: clk in 1, system clock; rst in 1, reset. Reset SHALL be asynchronous and active-high.
REQ-006 The module SHALL have fetch read ports: fetch_req_valid in 1, request; fetch_req_addr in ADDR_WIDTH, byte address; fetch_rsp_valid out 1, response valid; fetch_rsp_data out BUS_BYTES*8, bytes addr..addr+BUS_BYTES-1, little-endian; fetch_rsp_err out 1, range error.
REQ-007 The module SHALL have load ports: ld_req_valid in 1; ld_req_addr in ADDR_WIDTH; ld_req_size in SIZE_WIDTH; ld_rsp_valid out 1; ld_rsp_data out BUS_BYTES*8; ld_rsp_err out 1.
REQ-008 The module SHALL have store ports: st_req_valid in 1; st_req_addr in ADDR_WIDTH; st_req_size in SIZE_WIDTH; st_req_data in BUS_BYTES*8, byte 0 at addr; st_err out 1, registered store error.

Function
REQ-009 All ports SHALL always accept requests: one fetch, one load and one store per cycle, with no back-pressure.
REQ-010 Size encoding SHALL be 0=1B, 1=2B, 2=4B, 3=8B; a size whose byte count exceeds BUS_BYTES SHALL be an error.
REQ-011 Accesses SHALL be byte-granular and unaligned; a row-crossing access SHALL use row R for high banks and row R+1 for low banks in the same cycle.
REQ-012 A request SHALL be an error when offset=addr-BASE_ADDR is outside [0, TCM_SIZE-nbytes] (fetch nbytes=BUS_BYTES); there is no wrap at the TCM end.
REQ-013 An erroneous store SHALL write nothing; an erroneous read SHALL return data 0 with err=1.
REQ-014 Read response valid/data/err SHALL appear exactly 1+OUT_REG cycles after the request cycle, in order.
REQ-015 Load data SHALL be zero-extended above nbytes*8 bits.
REQ-016 Writes SHALL commit on the clock edge of the request cycle, per-bank byte enable, one shared storage array.
REQ-017 A same-cycle read overlapping a store SHALL return the new store bytes (write-first) for overlapping bytes and old data for the rest.
REQ-018 st_err SHALL assert for exactly one cycle, the cycle after an erroneous store.
REQ-019 With OUT_REG=1, a store in the cycle between read-array access and response SHALL NOT alter that already-read response.

Reset
REQ-020 While rst is high, fetch_rsp_valid, ld_rsp_valid, st_err and all err flags SHALL be 0, with response data 0.
REQ-021 Reset SHALL flush in-flight responses; requests issued during reset SHALL produce no response.
REQ-022 Memory contents SHALL be preserved across reset and uninitialised at power-up.

Structure
REQ-023 SIZE_WIDTH, the size enum and a size-to-bytecount function SHALL reside in the shared common package.
REQ-024 The module SHALL instantiate BUS_BYTES copies of one sub-module, tcm_bank: 8-bit wide, TCM_SIZE/BUS_BYTES deep, 1 write port and 2 synchronous read ports with write-first bypass.
REQ-025 Address rotation/row selection and response byte recombination SHALL be shared logic used by all three ports.

Verification (BUS_BYTES=8, BASE_ADDR=0x8000_0000)
REQ-026 Store 0x1122334455667788 size 3 at 0x8000_0004, then fetch at 0x8000_0000 -> after 1 cycle data=0x55667788_xxxxxxxx, with the upper word equal to the store's low word in bytes 4..7.
REQ-027 Store 0xAABB size 1 at 0x8000_0007 (row crossing), then load size 1 at the same address -> ld_rsp_data=0x000000000000AABB, err=0.
REQ-028 Same cycle: store 0xEE size 0 at 0x8000_0010 and load size 2 at 0x8000_0010 over old 0x44332211 -> ld_rsp_data=0x443322EE.
REQ-029 Store size 2 at 0x8000_FFFE -> st_err=1 one cycle later and memory unchanged; fetch at 0x7FFF_FFF8 -> fetch_rsp_err=1, data 0.
REQ-030 With OUT_REG=1, issue back-to-back loads, assert rst in cycle 1 -> no ld_rsp_valid for either load; memory retains prior data afterwards.
